// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//
// Plays a four-frame, two-LED pattern onto the board LEDs {IOT_50B, IOT_51A}.
// Frames advance every STEP_CYCLES clocks while RUN is high, and lit LEDs are
// dimmed by a free-running PWM gate. New patterns are loaded through a
// valid/ready port. While a pattern is playing, one further pattern can wait
// in a pending slot and takes over at the next 3->0 frame wrap.
//
// Ports
//   CLK        system clock, rising edge
//   RESETN     asynchronous active-low reset
//   PAT_VALID  pattern offer, held with stable data until accepted
//   PAT_READY  a pattern can be accepted this cycle
//   PAT_DATA   four frames, frame k = PAT_DATA[2k+1:2k], {IOT_50B, IOT_51A}
//   PAT_DUTY   PWM duty, captured together with PAT_DATA (all-ones = fully on)
//   RUN        level, 1 = play, 0 = stop
//   LEDS       registered LED drive {IOT_50B, IOT_51A}
//   FRAME      index of the frame on display
//   STEP       one-cycle pulse in the last cycle of each frame
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | LEDs dark, counters held at 0, loads go straight to active
// ST_RUN   | pattern playing, loads go to the pending slot

module led_pattern_sequencer #(
    parameter int unsigned STEP_CYCLES = 12000000,
    parameter int unsigned STEP_WIDTH  = 24,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                PAT_VALID,
    output logic                PAT_READY,
    input  logic [7:0]          PAT_DATA,
    input  logic [PWM_BITS-1:0] PAT_DUTY,
    input  logic                RUN,
    output logic [1:0]          LEDS,
    output logic [1:0]          FRAME,
    output logic                STEP
);

    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0]   DUTY_FULL = {PWM_BITS{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [7:0]            act_pat,   act_pat_next;
    logic [PWM_BITS-1:0]   act_duty,  act_duty_next;
    logic                  act_valid, act_valid_next;
    logic [7:0]            pend_pat,  pend_pat_next;
    logic [PWM_BITS-1:0]   pend_duty, pend_duty_next;
    logic                  pend_full, pend_full_next;
    logic [STEP_WIDTH-1:0] step_cnt,  step_cnt_next;
    logic [PWM_BITS-1:0]   pwm_cnt,   pwm_cnt_next;
    logic [1:0]            frame,     frame_next;
    logic [1:0]            leds_next;
    logic [1:0]            frame_bits;
    logic                  pwm_gate;
    logic                  hs;

    assign hs    = PAT_VALID & PAT_READY;
    assign FRAME = frame;

    // State register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a load in the same cycle as RUN is enough to start
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (RUN && (act_valid || hs)) state_next = ST_RUN;
            ST_RUN:  if (!RUN)                     state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        PAT_READY = 1'b1;
        STEP      = 1'b0;
        case (state)
            ST_IDLE: PAT_READY = 1'b1;
            ST_RUN: begin
                PAT_READY = ~pend_full;
                STEP      = (step_cnt == STEP_LAST);
            end
            default: PAT_READY = 1'b1;
        endcase
    end

    // Pattern storage, timing counters and next LED value
    always_comb begin
        act_pat_next   = act_pat;
        act_duty_next  = act_duty;
        act_valid_next = act_valid;
        pend_pat_next  = pend_pat;
        pend_duty_next = pend_duty;
        pend_full_next = pend_full;
        step_cnt_next  = step_cnt;
        pwm_cnt_next   = pwm_cnt;
        frame_next     = frame;

        case (state)
            ST_IDLE: begin
                step_cnt_next = '0;
                pwm_cnt_next  = '0;
                frame_next    = '0;
                if (hs) begin
                    act_pat_next   = PAT_DATA;
                    act_duty_next  = PAT_DUTY;
                    act_valid_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (!RUN) begin
                    // Stopping: the newest pattern offered becomes active so
                    // nothing is left stranded in the pending slot while idle.
                    step_cnt_next  = '0;
                    pwm_cnt_next   = '0;
                    frame_next     = '0;
                    pend_full_next = 1'b0;
                    if (hs) begin
                        act_pat_next  = PAT_DATA;
                        act_duty_next = PAT_DUTY;
                    end else if (pend_full) begin
                        act_pat_next  = pend_pat;
                        act_duty_next = pend_duty;
                    end
                end else begin
                    pwm_cnt_next = pwm_cnt + PWM_BITS'(1);
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_next = '0;
                        frame_next    = frame + 2'd1;
                        if (frame == 2'd3 && pend_full) begin
                            act_pat_next   = pend_pat;
                            act_duty_next  = pend_duty;
                            pend_full_next = 1'b0;
                        end
                    end else begin
                        step_cnt_next = step_cnt + STEP_WIDTH'(1);
                    end
                    // READY is low while pending is full, so this never
                    // collides with the promotion above.
                    if (hs) begin
                        pend_pat_next  = PAT_DATA;
                        pend_duty_next = PAT_DUTY;
                        pend_full_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        case (frame_next)
            2'd0:    frame_bits = act_pat_next[1:0];
            2'd1:    frame_bits = act_pat_next[3:2];
            2'd2:    frame_bits = act_pat_next[5:4];
            default: frame_bits = act_pat_next[7:6];
        endcase

        pwm_gate  = (pwm_cnt_next < act_duty_next) || (act_duty_next == DUTY_FULL);
        leds_next = (state_next == ST_RUN && pwm_gate) ? frame_bits : 2'b00;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            act_pat   <= '0;
            act_duty  <= '0;
            act_valid <= 1'b0;
            pend_pat  <= '0;
            pend_duty <= '0;
            pend_full <= 1'b0;
            step_cnt  <= '0;
            pwm_cnt   <= '0;
            frame     <= '0;
            LEDS      <= 2'b00;
        end else begin
            act_pat   <= act_pat_next;
            act_duty  <= act_duty_next;
            act_valid <= act_valid_next;
            pend_pat  <= pend_pat_next;
            pend_duty <= pend_duty_next;
            pend_full <= pend_full_next;
            step_cnt  <= step_cnt_next;
            pwm_cnt   <= pwm_cnt_next;
            frame     <= frame_next;
            LEDS      <= leds_next;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer with a short frame (4 cycles) and a
// 2-bit PWM. The reference model tracks how long the sequencer has been
// playing and derives frame, step and PWM phase from that with arithmetic.

module tb_led_pattern_sequencer;

    localparam int SC  = 4;
    localparam int PB  = 2;
    localparam int PWM_PERIOD = 1 << PB;
    localparam int DUTY_MAX   = PWM_PERIOD - 1;

    logic          CLK;
    logic          RESETN;
    logic          PAT_VALID;
    logic          PAT_READY;
    logic [7:0]    PAT_DATA;
    logic [PB-1:0] PAT_DUTY;
    logic          RUN;
    logic [1:0]    LEDS;
    logic [1:0]    FRAME;
    logic          STEP;

    led_pattern_sequencer #(
        .STEP_CYCLES(SC),
        .STEP_WIDTH (3),
        .PWM_BITS   (PB)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .PAT_VALID(PAT_VALID),
        .PAT_READY(PAT_READY),
        .PAT_DATA (PAT_DATA),
        .PAT_DUTY (PAT_DUTY),
        .RUN      (RUN),
        .LEDS     (LEDS),
        .FRAME    (FRAME),
        .STEP     (STEP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    typedef struct packed {
        logic [7:0]    pat;
        logic [PB-1:0] duty;
    } pat_t;

    pat_t     m_act;
    bit       m_act_valid;
    pat_t     m_pend[$];
    bit       m_run;
    int       m_t;        // cycles since playing started
    logic [1:0] m_leds;

    function automatic logic [1:0] model_leds(pat_t p, int t);
        int  fr;
        int  pw;
        bit  lit;
        fr  = (t / SC) % 4;
        pw  = t % PWM_PERIOD;
        lit = (pw < int'(p.duty)) || (int'(p.duty) == DUTY_MAX);
        return lit ? 2'((p.pat >> (2 * fr)) & 8'h03) : 2'b00;
    endfunction

    function automatic bit model_ready();
        return !m_run || (m_pend.size() == 0);
    endfunction

    task automatic model_reset();
        m_act       = '0;
        m_act_valid = 0;
        m_pend.delete();
        m_run       = 0;
        m_t         = 0;
        m_leds      = 2'b00;
    endtask

    // One clock cycle: check outputs, apply inputs, advance the model.
    task automatic drive_cycle(input bit run, input bit valid, input logic [7:0] data,
                               input logic [PB-1:0] duty, output bit accepted);
        pat_t nw;
        bit   hs;
        @(negedge CLK);
        chk("leds",  32'(LEDS),      32'(m_leds));
        chk("frame", 32'(FRAME),     32'(m_run ? (m_t / SC) % 4 : 0));
        chk("step",  32'(STEP),      32'(m_run && (m_t % SC == SC - 1)));
        chk("ready", 32'(PAT_READY), 32'(model_ready()));
        RUN       = run;
        PAT_VALID = valid;
        PAT_DATA  = data;
        PAT_DUTY  = duty;
        nw.pat  = data;
        nw.duty = duty;
        hs = valid && model_ready();
        if (!m_run) begin
            if (hs) begin
                m_act       = nw;
                m_act_valid = 1;
            end
            if (run && m_act_valid) begin
                m_run = 1;
                m_t   = 0;
            end
        end else if (!run) begin
            if (hs) m_act = nw;
            else if (m_pend.size() != 0) m_act = m_pend.pop_front();
            m_pend.delete();
            m_run = 0;
            m_t   = 0;
        end else begin
            if ((m_t % (4 * SC)) == 4 * SC - 1 && m_pend.size() != 0)
                m_act = m_pend.pop_front();
            if (hs) m_pend.push_back(nw);
            m_t++;
        end
        m_leds   = m_run ? model_leds(m_act, m_t) : 2'b00;
        accepted = hs;
    endtask

    task automatic idle_cycles(input bit run, input int n);
        bit a;
        for (int i = 0; i < n; i++) drive_cycle(run, 1'b0, 8'h00, '0, a);
    endtask

    task automatic offer(input bit run, input logic [7:0] data, input logic [PB-1:0] duty,
                         input int limit);
        bit a;
        a = 0;
        for (int i = 0; i < limit && !a; i++) drive_cycle(run, 1'b1, data, duty, a);
        chk("accept_bound", 32'(a), 32'd1);
    endtask

    task automatic run_until_t(input int target, input int limit);
        bit a;
        for (int i = 0; i < limit && !(m_run && m_t == target); i++)
            drive_cycle(1'b1, 1'b0, 8'h00, '0, a);
        chk("reach_t", 32'(m_t), 32'(target));
    endtask

    bit         o_active;
    logic [7:0] o_data;
    logic [1:0] o_duty;
    bit         r_run;
    bit         acc;

    initial begin
        RESETN    = 1'b0;
        RUN       = 1'b0;
        PAT_VALID = 1'b0;
        PAT_DATA  = 8'h00;
        PAT_DUTY  = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_leds",  32'(LEDS),      32'd0);
        chk("rst_frame", 32'(FRAME),     32'd0);
        chk("rst_step",  32'(STEP),      32'd0);
        chk("rst_ready", 32'(PAT_READY), 32'd1);
        @(negedge CLK);
        RESETN = 1'b1;

        // Idle load then run: 11,10,01,00 each for 4 cycles
        drive_cycle(1'b0, 1'b1, 8'b00_01_10_11, 2'd3, acc);
        idle_cycles(1'b1, 40);

        // PWM gating, load and start in the same cycle
        idle_cycles(1'b0, 2);
        offer(1'b1, 8'hFF, 2'd1, 4);
        idle_cycles(1'b1, 20);
        idle_cycles(1'b0, 2);
        offer(1'b1, 8'hFF, 2'd0, 4);
        idle_cycles(1'b1, 16);

        // Pending buffer and a stalled third offer
        idle_cycles(1'b0, 2);
        offer(1'b0, 8'h1B, 2'd3, 4);
        idle_cycles(1'b1, 5);
        offer(1'b1, 8'hE4, 2'd3, 4);
        offer(1'b1, 8'h55, 2'd2, 40);
        idle_cycles(1'b1, 40);

        // Stop at frame 2, count 1, then restart
        idle_cycles(1'b0, 2);
        offer(1'b0, 8'b00_01_10_11, 2'd3, 4);
        run_until_t(2 * SC + 1, 40);
        idle_cycles(1'b0, 3);
        idle_cycles(1'b1, 12);

        // Handshake exactly in the wrap cycle with pending empty
        idle_cycles(1'b0, 2);
        offer(1'b0, 8'h1B, 2'd3, 4);
        run_until_t(4 * SC - 1, 40);
        offer(1'b1, 8'hB4, 2'd3, 2);
        idle_cycles(1'b1, 40);

        // Async reset mid-run with a full pending slot
        idle_cycles(1'b0, 2);
        offer(1'b1, 8'hFF, 2'd3, 4);
        idle_cycles(1'b1, 2);
        offer(1'b1, 8'hAA, 2'd3, 4);
        idle_cycles(1'b1, 1);
        @(posedge CLK);
        #2;
        RESETN    = 1'b0;
        RUN       = 1'b0;
        PAT_VALID = 1'b0;
        #1;
        chk("arst_leds",  32'(LEDS),      32'd0);
        chk("arst_ready", 32'(PAT_READY), 32'd1);
        chk("arst_frame", 32'(FRAME),     32'd0);
        model_reset();
        @(negedge CLK);
        RESETN = 1'b1;
        idle_cycles(1'b1, 12);

        // Randomized play with held offers and RUN toggling
        o_active = 0;
        o_data   = 8'h00;
        o_duty   = 2'd0;
        r_run    = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!o_active && ($urandom % 4 == 0)) begin
                o_active = 1;
                o_data   = 8'($urandom);
                o_duty   = 2'($urandom_range(0, 3));
            end
            if ($urandom % 40 == 0) r_run = ~r_run;
            drive_cycle(r_run, o_active, o_data, o_duty, acc);
            if (acc) o_active = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Drives the two board LEDs (IOT_50B, IOT_51A) from a software-loaded four-frame pattern, stepping frames at a fixed prescaled rate and dimming lit LEDs with a PWM duty setting. It sits directly upstream of the SOC LED pins. The control side is fed through a one-entry valid/ready pattern buffer, so a new pattern can be queued while the current one plays. The LED bench observes its output as LEDS = {IOT_50B, IOT_51A}.

## Interface
- STEP_CYCLES, default 12000000: clock cycles per pattern frame; legal range ≥2.
- STEP_WIDTH, default 24: width of the step counter; must satisfy 2^STEP_WIDTH ≥ STEP_CYCLES.
- PWM_BITS, default 4: width of the PWM counter and of DUTY.
- CLK  in  1  system clock; all state changes on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- PAT_VALID  in  1  pattern offer; must be held, with its data stable, until accepted.
- PAT_READY  out  1  buffer can accept a pattern this cycle.
- PAT_DATA  in  8  four frames; frame k is PAT_DATA[2k+1:2k], bit 1 drives IOT_50B and bit 0 drives IOT_51A.
- PAT_DUTY  in  PWM_BITS  brightness; captured together with PAT_DATA.
- RUN  in  1  level; 1 = play the pattern, 0 = stop.
- LEDS  out  2  registered; {IOT_50B, IOT_51A}.
- FRAME  out  2  index of the frame currently displayed.
- STEP  out  1  one-cycle pulse on each frame advance.

## Operation
- Storage:
  - active register: pattern + duty + `act_valid`.
  - pending register: pattern + duty + `pend_full`.
- A handshake fires on a cycle with PAT_VALID & PAT_READY.
- States:
  - IDLE:
    - PAT_READY = 1.
    - A handshake writes the active register directly and sets `act_valid`.
    - Go to RUNNING when RUN=1 and `act_valid`=1. A handshake in the same cycle supplies the pattern used.
  - RUNNING:
    - PAT_READY = ~pend_full.
    - A handshake writes the pending register and sets `pend_full`.
    - The step counter counts 0..STEP_CYCLES-1 and wraps.
    - At count STEP_CYCLES-1, FRAME increments modulo 4.
    - At the 3→0 wrap, if `pend_full`=1: pending moves to active and `pend_full` clears. A handshake in that same cycle is still accepted into pending, because READY was already 0 if pending was full.
    - RUN=0 → IDLE.
- Leaving RUNNING for IDLE:
  - Clears the step counter, PWM counter and FRAME.
  - If `pend_full`, promotes pending to active.
- PWM:
  - A free-running PWM_BITS counter advances every cycle in RUNNING and is held at 0 in IDLE.
  - A lit bit is driven 1 when pwm_cnt < duty, or when duty is all-ones (fully on).
  - duty=0 gives LEDs always off.
- LEDS is next-state registered from the active frame bits AND the PWM gate. It is 2'b00 in IDLE.

## Timing
- Reset values:
  - LEDS=00, FRAME=0, STEP=0, PAT_READY=1.
  - State IDLE, `act_valid`=0, `pend_full`=0, all counters 0.
  - Reset mid-run discards both patterns.
- Startup: the first LEDS update appears one cycle after the cycle in which RUNNING is entered. Frame 0 is shown first.
- Frame timing:
  - STEP is high for exactly the cycle in which the step counter equals STEP_CYCLES-1.
  - FRAME shows the new value on the following cycle, and LEDS shows the new frame on that same cycle.
  - Frame period is exactly STEP_CYCLES cycles.
- PAT_READY:
  - Falls the cycle after a RUNNING handshake.
  - Rises the cycle after the promotion at the 3→0 wrap, or after entry to IDLE.
- RUN deassert: LEDS=00 and FRAME=0 on the next cycle. No partial-frame completion.
- STEP is never asserted in IDLE.

## Test plan
- Idle load then run:
  - Setup: STEP_CYCLES=4, PWM_BITS=2, PAT_DATA=8'b00_01_10_11, duty=3, RUN raised next cycle.
  - Required: LEDS sequence 11,10,01,00, each held 4 cycles, repeating.
  - Required: STEP pulses every 4th cycle.
- PWM gating:
  - Setup: duty=1, pattern all 11.
  - Required: LEDS=11 one cycle in four, 00 otherwise.
  - Required: duty=0 gives a constant 00.
- Pending buffer:
  - Stimulus: while running pattern A, offer pattern B.
  - Required: PAT_READY drops the next cycle.
  - Required: B first appears on frame 0 after the current 3→0 wrap.
  - Required: a third offer stalls until that wrap.
- Stop mid-frame:
  - Stimulus: drop RUN at frame 2, count 1.
  - Required: next cycle LEDS=00, FRAME=0, STEP=0.
  - Required: re-raising RUN restarts at frame 0 with a full 4-cycle frame.
- Async reset:
  - Stimulus: assert RESETN=0 mid-run.
  - Required: LEDS=00 and PAT_READY=1 immediately, without waiting for a clock edge.
  - Required: after release, raising RUN without a new load stays in IDLE.
- Simultaneous events:
  - Stimulus: a handshake in the same cycle as the 3→0 wrap with `pend_full`=0.
  - Required: the pattern lands in pending and is promoted at the following wrap, i.e. after 16 cycles.
